// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
// Contents: loader state enum, bytes-per-word, default memory geometry
//   (also used by the top-level system so the loader and pc widths agree).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 6;
  localparam int DEFAULT_DEPTH  = 64;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port bundle
// Signals: rx_valid/rx_data/rx_ready (byte stream into the loader),
//   mem_we/mem_addr/mem_wdata (word writes out of the loader).
// Modports: slave = loader side, master = stream source / memory side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// rtl/imem_loader_word_assembler.sv - packs accepted bytes into little-endian 32-bit words
// Ports: clk, reset (async, active-high), clear (drop partial word),
//   in_valid/in_data (accepted byte), word_valid (pulse on 4th byte),
//   word (completed word, valid while word_valid is high).
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (in_valid) begin
      shreg_d[{cnt_q, 3'b000} +: 8] = in_data;
      // 2-bit counter wraps 3 -> 0, ready for the next word
      cnt_d = cnt_q + 2'd1;
    end
  end

  // The word is presented combinationally in the same cycle as its last byte
  // so the loader can register the memory write for the following cycle.
  assign word_valid = in_valid && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {in_data, shreg_q[23:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: framed byte stream to instruction-memory writes
// Ports: clk, reset (async, active-high), start (load pulse),
//   bus (slave: rx byte stream in, mem write port out),
//   cpu_reset (low only after a good load), busy, done, err.
// Frame: L (words-1), 4*(L+1) little-endian data bytes, XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_DEPTH
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        xor_q, xor_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic        accept;
  logic        asm_clear;
  logic        asm_valid;
  logic        word_valid;
  logic [31:0] word;

  assign accept    = bus.rx_valid && rx_ready_q;
  assign asm_clear = accept && (state_q == LEN);
  assign asm_valid = accept && (state_q == DATA);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .in_valid   (asm_valid),
    .in_data    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    xor_d       = xor_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (accept) begin
          // An out-of-range length is clamped so the word index cannot run
          // past the memory; the checksum still covers the raw byte.
          len_d   = (int'(bus.rx_data) > DEPTH - 1) ? ADDR_W'(DEPTH - 1)
                                                    : bus.rx_data[ADDR_W-1:0];
          idx_d   = '0;
          xor_d   = bus.rx_data;
          state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          xor_d = xor_q ^ bus.rx_data;
          if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q;
            mem_wdata_d = word;
            if (idx_q == len_q) state_d = CSUM;
            else                idx_d   = idx_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (xor_q == bus.rx_data) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state register.
    rx_ready_d  = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
    busy_d      = rx_ready_d;
    cpu_reset_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rx_ready_q  <= rx_ready_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_reset, busy, done, err;

  imem_loader_if #(.ADDR_W(6)) bus ();

  imem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t got[$];

  typedef struct {
    int          nwords;     // 0 = random 1..64
    bit          fixed;      // first word forced to w0
    logic [31:0] w0;
    bit          bad;        // send inverted checksum
    int          stall;      // percent chance of an idle cycle before each byte
    bit          start_busy; // hold start high on every non-final byte
    bit          start_csum; // start high together with the checksum byte
    bit          exp_done;
  } vec_t;

  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.mem_we === 1'b1) got.push_back('{bus.mem_addr, bus.mem_wdata, cyc});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0]  bq[$];
    logic [31:0] ew[$];
    logic [31:0] w;
    logic [7:0]  x;
    int          n;
    int          done_cyc;
    bit          ready_drop;
    n = (v.nwords == 0) ? int'($urandom_range(64, 1)) : v.nwords;
    // reference frame: words chosen first, bytes derived little-endian
    x = 8'(n - 1);
    bq.push_back(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      w = (i == 0 && v.fixed) ? v.w0 : $urandom;
      ew.push_back(w);
      for (int b = 0; b < 4; b++) begin
        bq.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
    bq.push_back(v.bad ? ~x : x);

    got.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_rx_ready", 32'(bus.rx_ready), 1);
    chk("start_busy", 32'(busy), 1);
    chk("start_cpu_reset", 32'(cpu_reset), 1);

    ready_drop = 1'b0;
    for (int k = 0; k < bq.size(); k++) begin
      for (int g = 0; g < 8 && v.stall > 0 && $urandom_range(99, 0) < v.stall; g++) begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        start        = 1'b0;
        if (bus.rx_ready !== 1'b1) ready_drop = 1'b1;
        @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = bq[k];
      start = (k == bq.size() - 1) ? v.start_csum : v.start_busy;
      if (bus.rx_ready !== 1'b1) ready_drop = 1'b1;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    start        = 1'b0;
    done_cyc     = cyc;

    chk("rx_ready_held", 32'(ready_drop), 0);
    chk("end_done", 32'(done), 32'(v.exp_done));
    chk("end_err", 32'(err), 32'(!v.exp_done));
    chk("end_busy", 32'(busy), 0);
    chk("end_cpu_reset", 32'(cpu_reset), 32'(!v.exp_done));
    chk("wr_count", 32'(got.size()), 32'(n));
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk("wr_addr", 32'(got[i].addr), 32'(i));
      chk("wr_data", got[i].data, ew[i]);
      if (v.stall == 0 && i > 0) chk("wr_spacing", 32'(got[i].c - got[i-1].c), 4);
    end
    if (got.size() >= n) chk("wr_before_done", 32'(got[n-1].c < done_cyc), 1);

    // stray bytes (and a start held low) after the frame must be ignored
    for (int k = 0; k < 6; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chk("post_rx_ready", 32'(bus.rx_ready), 0);
    chk("post_wr_count", 32'(got.size()), 32'(n));
    chk("post_done", 32'(done), 32'(v.exp_done));
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1,  1, 32'h0000_0013, 0, 0,  0, 0, 1};
    vecs[1] = '{64, 0, 32'h0,         0, 0,  0, 0, 1};
    vecs[2] = '{2,  0, 32'h0,         1, 0,  0, 0, 0};
    vecs[3] = '{2,  0, 32'h0,         0, 0,  0, 1, 1};
    vecs[4] = '{2,  0, 32'h0,         0, 50, 1, 0, 1};
    vecs[5] = '{0,  0, 32'h0,         0, 30, 0, 0, 1};
    vecs[6] = '{0,  0, 32'h0,         1, 20, 0, 0, 0};
    vecs[7] = '{3,  0, 32'h0,         0, 0,  0, 0, 1};

    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_reset", 32'(cpu_reset), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b0;

    // stray traffic in IDLE
    got.delete();
    for (int k = 0; k < 4; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_rx_ready", 32'(bus.rx_ready), 0);
    end
    bus.rx_valid = 1'b0;
    chk("idle_no_write", 32'(got.size()), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cpu_reset", 32'(cpu_reset), 1);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // asynchronous reset from DONE: cpu_reset must rise without a clock edge
    chk("pre_async_cpu_reset", 32'(cpu_reset), 0);
    #2 reset = 1'b1;
    #1 chk("async_cpu_reset", 32'(cpu_reset), 1);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // reset after the 6th data byte of a 2-word frame
    got.delete();
    @(negedge clk);
    pulse_start();
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h01;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      bus.rx_data = 8'(8'hA0 + k);
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chk("midrst_pre_writes", 32'(got.size()), 1);
    if (got.size() >= 1) chk("midrst_word0", got[0].data, 32'hA3A2A1A0);
    #2 reset = 1'b1;
    #1 chk("midrst_cpu_reset", 32'(cpu_reset), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_no_more_writes", 32'(got.size()), 1);
    chk("midrst_idle_busy", 32'(busy), 0);
    chk("midrst_idle_done", 32'(done), 0);
    chk("midrst_idle_err", 32'(err), 0);
    run_frame('{2, 0, 32'h0, 0, 0, 0, 0, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory in the single-cycle system. It accepts a framed byte stream (length, little-endian instruction words, XOR checksum) over a valid/ready handshake, packs bytes into 32-bit words, and writes them to sequential instruction-memory word addresses. It holds the CPU in reset until a load completes with a correct checksum, so the CPU's first fetch at pc = 0 sees a fully loaded program.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width; matches the 6-bit pc
- DEPTH, 64, words of instruction memory, equal to 2**ADDR_W

Ports (single clock; asynchronous, active-high reset):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR
- rx_valid  in  1  byte-stream valid
- rx_data  in  8  byte-stream data
- rx_ready  out  1  loader can accept a byte
- mem_we  out  1  instruction-memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  instruction word to write
- cpu_reset  out  1  holds the CPU in reset; low only in DONE
- busy  out  1  load in progress (LEN, DATA or CSUM)
- done  out  1  last load succeeded
- err  out  1  last load failed its checksum

## Operation
- Frame format: byte 0 = L, the word count minus one (0..DEPTH-1, so 1..64 words). Then 4*(L+1) data bytes, little-endian: the first byte of each word goes to [7:0], the fourth to [31:24]. Then one checksum byte.
- A byte is accepted on any cycle with rx_valid && rx_ready. rx_ready = 1 in LEN, DATA and CSUM; otherwise 0. No other backpressure.
- Checksum: XOR of L and every data byte. It must equal the CSUM byte.
- State transitions:
  - IDLE: start → LEN.
  - LEN: on accept, latch L, clear the byte counter, word index and running XOR → DATA.
  - DATA: each accept shifts the byte into the packer. On the 4th byte of a word, register a write. When the word index equals L and the 4th byte is accepted → CSUM.
  - CSUM: on accept, go to DONE if the checksum matches, else ERROR.
  - DONE or ERROR: start → LEN.
- start is ignored while busy. rx traffic in IDLE, DONE or ERROR is not accepted.
- Output flags:
  - cpu_reset = 1 in every state except DONE.
  - done = 1 only in DONE; err = 1 only in ERROR.
  - busy = 1 in LEN, DATA and CSUM.
- Words already written are not rolled back on ERROR. The CPU stays held in reset.
- Reset mid-load:
  - Returns to IDLE and drops the partial word.
  - cpu_reset reasserts immediately (asynchronously).
  - Memory contents are left as they are.

## Timing
- Reset values:
  - rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0
  - cpu_reset 1, busy 0, done 0, err 0
  - state IDLE, counters 0
- start sampled at cycle t → LEN (rx_ready = 1) at t+1.
- 4th byte of word k accepted at cycle t → mem_we = 1, mem_addr = k, mem_wdata = word at t+1, for exactly one cycle.
- Back-to-back bytes at full rate give one write every 4 cycles. Gaps in rx_valid stretch this without losing data.
- The last word's write occurs the cycle after its 4th byte, so it is always strictly before DONE.
- CSUM byte accepted at t → at t+1: done/err valid, busy = 0, and cpu_reset = 0 if the checksum matched.
- Word index never wraps: L ≤ DEPTH-1 bounds it. L = 63 writes addresses 0..63.
- start arriving in the same cycle as the CSUM accept is ignored (busy).

## Structure
- Package imem_loader_pkg holds:
  - state enum (IDLE, LEN, DATA, CSUM, DONE, ERROR)
  - BYTES_PER_WORD = 4
  - default ADDR_W / DEPTH constants, shared with the top-level system module
- Sub-module word_assembler:
  - 2-bit byte counter and 32-bit little-endian shift/insert register
  - clear input
  - word_valid output pulse on the 4th byte
- The FSM, word index, XOR accumulator and registered write port live in imem_loader.

## Test plan
- Single word: start, then bytes 00, 13, 00, 00, 00, XOR 13 → one write, addr 0, data 0x00000013. Next cycle done = 1, cpu_reset = 0.
- Full memory: L = 3F, 256 data bytes at full rate, correct checksum → 64 writes, addr 0..63 in order, 4 cycles apart. No write after DONE.
- Bad checksum: valid 2-word frame with CSUM byte inverted → both words written, then err = 1, done = 0, cpu_reset stays 1. A following start plus a good frame → DONE.
- Stalls: same 2-word frame with rx_valid toggling randomly → identical write addr/data sequence. rx_ready never drops during the load.
- Reset mid-load: assert reset after the 6th data byte → cpu_reset 1, state IDLE, no further mem_we. Next start plus a full frame reloads from addr 0.
- start while busy and stray rx bytes in IDLE/DONE → no state change, rx_ready 0, no writes.
